// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, width helpers and parity-mode
// constants (the parity constants are meant to be reused by the transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_WAIT_IDLE
  } uart_rx_state_e;

  localparam bit UART_PARITY_EVEN = 1'b0;
  localparam bit UART_PARITY_ODD  = 1'b1;

  function automatic int uart_cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

  function automatic int uart_idx_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer followed by a registered 2-of-3 majority vote over the
// last three synchronized samples; idles (and resets) high like a UART line.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] tap_q;
  logic       maj;

  // Window = newest synchronized sample plus the two before it.
  assign maj = (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      tap_q  <= '1;
      q_o    <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], d_i};
      tap_q  <= {tap_q[0], sync_q[1]};
      q_o    <= maj;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: voted input, mid-bit sampling, configurable data/parity/stop
// format, per-frame parity, framing and break status.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_serial_i,
  output logic                 rx_dv_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 busy_o
);

  localparam int CNT_W = uart_cnt_w(CLKS_PER_BIT);
  localparam int IDX_W = uart_idx_w(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD_BIT   = (PARITY_ODD != 0) ? UART_PARITY_ODD : UART_PARITY_EVEN;

  uart_rx_state_e       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 rx_v;
  logic                 bit_tick;

  uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_serial_i),
    .q_o   (rx_v)
  );

  assign bit_tick = (cnt_q == FULL_M1);
  assign busy_o   = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        stop_d = 1'b0;
        if (!rx_v) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_v) begin
            // Per-frame status starts clean so flags never leak across frames.
            state_d = ST_DATA;
            data_d  = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            zero_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_d  = '0;
          data_d = {rx_v, data_q[DATA_BITS-1:1]};
          zero_d = zero_q & ~rx_v;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          perr_d  = (^data_q) ^ rx_v ^ ODD_BIT;
          zero_d  = zero_q & ~rx_v;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          cnt_d  = '0;
          zero_d = zero_q & ~rx_v;
          if (!rx_v) ferr_d = 1'b1;
          if (stop_q == LAST_STOP) begin
            stop_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A framing error may mean a held-low break; wait for the line to recover.
      ST_DONE:      state_d = ferr_q ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: if (rx_v) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_dv_o      <= 1'b0;
      rx_data_o    <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      rx_dv_o <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        rx_data_o    <= data_q;
        parity_err_o <= perr_q;
        frame_err_o  <= ferr_q;
        break_o      <= zero_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Three receivers (8N1, 8E1, 7O2) driven one at a time; expected frames are queued
// at send time and checked by a monitor whenever any receiver pulses rx_dv_o.
module tb_uart_rx_ext;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_ln = '1;
  logic [2:0] dv, perr, ferr, brk, busy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] dat [3];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {int ch; int d; int p; int f; int b; int t;} exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {2'b0, d2};

  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(rx_ln[0]), .rx_dv_o(dv[0]), .rx_data_o(d0),
    .parity_err_o(perr[0]), .frame_err_o(ferr[0]), .break_o(brk[0]), .busy_o(busy[0]));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(rx_ln[1]), .rx_dv_o(dv[1]), .rx_data_o(d1),
    .parity_err_o(perr[1]), .frame_err_o(ferr[1]), .break_o(brk[1]), .busy_o(busy[1]));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_7o2 (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(rx_ln[2]), .rx_dv_o(dv[2]), .rx_data_o(d2),
    .parity_err_o(perr[2]), .frame_err_o(ferr[2]), .break_o(brk[2]), .busy_o(busy[2]));

  function automatic int nb(input int ch); return (ch == 2) ? 7 : 8; endfunction
  function automatic int pe(input int ch); return (ch != 0) ? 1 : 0; endfunction
  function automatic int po(input int ch); return (ch == 2) ? 1 : 0; endfunction
  function automatic int sb(input int ch); return (ch == 2) ? 2 : 1; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame as a bit list, LSB = start bit; parity chosen like a transmitter would.
  task automatic build(input int ch, input int data, input int badp, input int stops,
                       output int fb, output int len);
    int pos, pb;
    fb = 0;
    pos = 1;
    for (int i = 0; i < nb(ch); i++) begin
      fb |= ((data >> i) & 1) << pos;
      pos++;
    end
    if (pe(ch) != 0) begin
      pb = ($countones(data & ((1 << nb(ch)) - 1)) & 1) ^ po(ch) ^ badp;
      fb |= pb << pos;
      pos++;
    end
    for (int s = 0; s < sb(ch); s++) begin
      fb |= ((stops >> s) & 1) << pos;
      pos++;
    end
    len = pos;
  endtask

  // Reference: decode the frame from its bit list; dv expected at a fixed offset
  // from the final stop bit's centre (front-end delay plus the DONE cycle).
  task automatic expect_frame(input int ch, input int fb, input int len, input int c0);
    exp_t e;
    int pb, ones;
    e.ch = ch;
    e.d  = (fb >> 1) & ((1 << nb(ch)) - 1);
    e.p  = 0;
    if (pe(ch) != 0) begin
      pb   = (fb >> (nb(ch) + 1)) & 1;
      ones = $countones(e.d) + pb;
      e.p  = (po(ch) != 0) ? ((ones % 2) == 0 ? 1 : 0) : ((ones % 2) == 1 ? 1 : 0);
    end
    e.f = 0;
    for (int s = len - sb(ch); s < len; s++)
      if (((fb >> s) & 1) == 0) e.f = 1;
    e.b = (((fb >> 1) & ((1 << (len - 1)) - 1)) == 0) ? 1 : 0;
    e.t = c0 + 6 + CPB / 2 + CPB * (len - 1);
    sbq.push_back(e);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive(input int ch, input int fb, input int len, input int spike, input int maxc);
    for (int c = 0; c < len * CPB && c < maxc; c++) begin
      rx_ln[ch] = (((fb >> (c / CPB)) & 1) != 0) ^ (c == spike);
      @(negedge clk);
    end
  endtask

  task automatic frame(input int ch, input int data, input int badp, input int stops, input int spike);
    int fb, len;
    build(ch, data, badp, stops, fb, len);
    expect_frame(ch, fb, len, cyc);
    drive(ch, fb, len, spike, len * CPB);
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      if (dv[ch] === 1'b1) begin
        if (sbq.size() == 0) begin
          chk($sformatf("ch%0d unexpected rx_dv", ch), 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("ch%0d frame source", ch), ch, e.ch);
          chk($sformatf("ch%0d rx_data", ch), int'(dat[ch]), e.d);
          chk($sformatf("ch%0d parity_err", ch), int'(perr[ch]), e.p);
          chk($sformatf("ch%0d frame_err", ch), int'(ferr[ch]), e.f);
          chk($sformatf("ch%0d break", ch), int'(brk[ch]), e.b);
          chk($sformatf("ch%0d dv cycle", ch), cyc, e.t);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d frames outstanding", sbq.size());
    $fatal(1);
  end

  initial begin
    int fb, len;
    repeat (3) @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      chk($sformatf("ch%0d reset rx_data", ch), int'(dat[ch]), 0);
      chk($sformatf("ch%0d reset flags", ch), int'({perr[ch], ferr[ch], brk[ch]}), 0);
      chk($sformatf("ch%0d reset busy/dv", ch), int'({busy[ch], dv[ch]}), 0);
    end
    rst_n = 1'b1;
    hold(4);

    // 8N1 basic frame, then outputs must hold between pulses.
    frame(0, 'hA5, 0, 1, -1);
    hold(20);
    chk("ch0 data holds", int'(dat[0]), 'hA5);

    // 8E1 with wrong then right parity bit.
    frame(1, 'h3C, 1, 1, -1);
    hold(3);
    frame(1, 'h3C, 0, 1, -1);
    hold(3);

    // 7O2 with second stop bit low, line kept low afterwards.
    frame(2, 'h55, 0, 'b01, -1);
    hold(40);
    chk("ch2 busy in wait-idle", int'(busy[2]), 1);
    rx_ln[2] = 1'b1;
    hold(6);
    chk("ch2 idle after line high", int'(busy[2]), 0);

    // Start glitch: 3 low cycles must not produce a frame.
    rx_ln[0] = 1'b0;
    hold(3);
    rx_ln[0] = 1'b1;
    hold(3);
    chk("glitch seen as start", int'(busy[0]), 1);
    hold(7);
    chk("glitch rejected, idle", int'(busy[0]), 0);

    // Break: line low for 3 frame times yields exactly one flagged frame.
    build(0, 0, 0, 0, fb, len);
    expect_frame(0, fb, len, cyc);
    drive(0, fb, len, -1, len * CPB);
    hold(20 * CPB);
    rx_ln[0] = 1'b1;
    hold(20);
    frame(0, 'h81, 0, 1, -1);
    hold(4);

    // Reset during data bit 4 of 0xFF.
    build(0, 'hFF, 0, 1, fb, len);
    drive(0, fb, len, -1, 5 * CPB + CPB / 2);
    rst_n = 1'b0;
    hold(2);
    chk("mid-frame reset rx_data", int'(dat[0]), 0);
    chk("mid-frame reset flags", int'({perr[0], ferr[0], brk[0]}), 0);
    chk("mid-frame reset busy/dv", int'({busy[0], dv[0]}), 0);
    rx_ln[0] = 1'b1;
    hold(2);
    rst_n = 1'b1;
    hold(4);
    // One-cycle high spike in the middle of data bit 0 (a zero).
    frame(0, 'h12, 0, 1, CPB + CPB / 2);
    hold(4);

    // Random frames, back-to-back gaps of 0..3 cycles.
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 8; k++) begin
        int data, badp;
        data = int'($urandom_range(0, (1 << nb(ch)) - 1));
        badp = (pe(ch) != 0) ? int'($urandom_range(0, 1)) : 0;
        frame(ch, data, badp, (sb(ch) == 2) ? 3 : 1, -1);
        hold(int'($urandom_range(0, 3)));
      end
      hold(10);
    end

    for (int i = 0; i < 400 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
